// File: rtl/breakpoint_unit_pkg.sv
// Shared definitions for the breakpoint unit and its neighbours in the clock/halt block.
package breakpoint_unit_pkg;

    // Default widths; the clock block sizes its debug buses with these.
    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_CNT_WIDTH  = 8;

    // State encoding of the halt FSM.
    localparam logic [1:0] ST_ARMED  = 2'd0;
    localparam logic [1:0] ST_HIT    = 2'd1;
    localparam logic [1:0] ST_RESUME = 2'd2;

    typedef enum logic [1:0] {
        STATE_ARMED  = ST_ARMED,
        STATE_HIT    = ST_HIT,
        STATE_RESUME = ST_RESUME
    } bpState_t;

endpackage

// File: rtl/bp_match_array.sv
// Breakpoint slot storage plus parallel PC compare with lowest-index priority.
module bp_match_array
    import breakpoint_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_BP     = 4,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_bpWrite,
    input  logic [IDX_WIDTH-1:0]  i_bpIndex,
    input  logic [ADDR_WIDTH-1:0] i_bpAddr,
    input  logic                  i_bpValid,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic                  o_anyMatch,
    output logic [IDX_WIDTH-1:0]  o_matchIndex
);

    logic [ADDR_WIDTH-1:0] slotAddr_r [NUM_BP];
    logic [NUM_BP-1:0]     slotValid_r;
    logic [NUM_BP-1:0]     hitVec_s;
    logic [IDX_WIDTH-1:0]  matchIndex_s;

    // Slot registers: cleared on reset, one slot rewritten per write strobe.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            for (int k = 0; k < NUM_BP; k++) begin
                slotAddr_r[k] <= '0;
            end
            slotValid_r <= '0;
        end else if (i_bpWrite) begin
            slotAddr_r[i_bpIndex]  <= i_bpAddr;
            slotValid_r[i_bpIndex] <= i_bpValid;
        end
    end

    // Per-slot full-width equality against the fetch address.
    always_comb begin
        hitVec_s = '0;
        for (int k = 0; k < NUM_BP; k++) begin
            hitVec_s[k] = slotValid_r[k] && (slotAddr_r[k] == i_pc);
        end
    end

    // Priority encode: scanning downward leaves the lowest matching slot.
    always_comb begin
        matchIndex_s = '0;
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            matchIndex_s = hitVec_s[k] ? IDX_WIDTH'(k) : matchIndex_s;
        end
    end

    assign o_anyMatch   = |hitVec_s;
    assign o_matchIndex = matchIndex_s;

endmodule

// File: rtl/breakpoint_unit.sv
// PC breakpoint unit: latches a hit until resume, with a global skip count and
// a one-fetch suppression window after resume so the halting fetch does not re-hit.
module breakpoint_unit
    import breakpoint_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_BP     = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_breakpointEnableN,
    input  logic                  i_fetchValid,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_bpWrite,
    input  logic [IDX_WIDTH-1:0]  i_bpIndex,
    input  logic [ADDR_WIDTH-1:0] i_bpAddr,
    input  logic                  i_bpValid,
    input  logic                  i_skipWrite,
    input  logic [CNT_WIDTH-1:0]  i_skipCount,
    input  logic                  i_resume,
    output logic                  o_breakpointHitN,
    output logic [IDX_WIDTH-1:0]  o_hitIndex,
    output logic [CNT_WIDTH-1:0]  o_hitCount,
    output logic [CNT_WIDTH-1:0]  o_skipRemaining
);

    bpState_t              state_r;
    logic                  hitN_r;
    logic [IDX_WIDTH-1:0]  hitIndex_r;
    logic [CNT_WIDTH-1:0]  hitCount_r;
    logic [CNT_WIDTH-1:0]  skip_r;
    logic                  anyMatch_s;
    logic [IDX_WIDTH-1:0]  matchIndex_s;
    logic                  match_s;

    bp_match_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_BP     (NUM_BP),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_matchArray (
        .i_clk        (i_clk),
        .i_resetn     (i_resetn),
        .i_bpWrite    (i_bpWrite),
        .i_bpIndex    (i_bpIndex),
        .i_bpAddr     (i_bpAddr),
        .i_bpValid    (i_bpValid),
        .i_pc         (i_pc),
        .o_anyMatch   (anyMatch_s),
        .o_matchIndex (matchIndex_s)
    );

    // A match only counts on a fetch strobe while breakpoints are enabled.
    assign match_s = i_fetchValid && !i_breakpointEnableN && anyMatch_s;

    // Halt FSM, skip counter and saturating hit counter.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state_r    <= STATE_ARMED;
            hitN_r     <= 1'b1;
            hitIndex_r <= '0;
            hitCount_r <= '0;
            skip_r     <= '0;
        end else begin
            if (i_breakpointEnableN) begin
                // Disabling drops any halt but keeps slots and counters.
                state_r <= STATE_ARMED;
                hitN_r  <= 1'b1;
            end else begin
                case (state_r)
                    STATE_ARMED: begin
                        if (match_s) begin
                            if (skip_r != '0) begin
                                skip_r <= skip_r - CNT_WIDTH'(1);
                            end else begin
                                state_r    <= STATE_HIT;
                                hitN_r     <= 1'b0;
                                hitIndex_r <= matchIndex_s;
                                if (hitCount_r != '1) begin
                                    hitCount_r <= hitCount_r + CNT_WIDTH'(1);
                                end
                            end
                        end
                    end
                    STATE_HIT: begin
                        // Fetches are ignored while halted, even one coinciding with resume.
                        if (i_resume) begin
                            state_r <= STATE_RESUME;
                            hitN_r  <= 1'b1;
                        end
                    end
                    STATE_RESUME: begin
                        // Swallow the re-fetch of the instruction we stopped on.
                        if (i_fetchValid) begin
                            state_r <= STATE_ARMED;
                        end
                    end
                    default: begin
                        state_r <= STATE_ARMED;
                        hitN_r  <= 1'b1;
                    end
                endcase
            end
            // An explicit load overrides any decrement in the same cycle.
            if (i_skipWrite) begin
                skip_r <= i_skipCount;
            end
        end
    end

    assign o_breakpointHitN = hitN_r;
    assign o_hitIndex       = hitIndex_r;
    assign o_hitCount       = hitCount_r;
    assign o_skipRemaining  = skip_r;

endmodule

// File: tb/tb_breakpoint_unit.sv
// Directed, table-driven bench for breakpoint_unit.
module tb_breakpoint_unit;

    logic        clk;
    logic        resetn;
    logic        enN;
    logic        fetchValid;
    logic [15:0] pc;
    logic        bpWrite;
    logic [1:0]  bpIndex;
    logic [15:0] bpAddr;
    logic        bpValid;
    logic        skipWrite;
    logic [7:0]  skipCount;
    logic        resume;
    logic        hitN;
    logic [1:0]  hitIndex;
    logic [7:0]  hitCount;
    logic [7:0]  skipRem;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rn;
        logic        en;
        logic        fv;
        logic [15:0] pc;
        logic        w;
        logic [1:0]  wi;
        logic [15:0] wa;
        logic        wv;
        logic        sw;
        logic [7:0]  sc;
        logic        rs;
        logic        eHitN;
        logic [1:0]  eIdx;
        logic [7:0]  eCnt;
        logic [7:0]  eSkip;
    } vec_t;

    vec_t vecs[$];

    breakpoint_unit dut (
        .i_clk               (clk),
        .i_resetn            (resetn),
        .i_breakpointEnableN (enN),
        .i_fetchValid        (fetchValid),
        .i_pc                (pc),
        .i_bpWrite           (bpWrite),
        .i_bpIndex           (bpIndex),
        .i_bpAddr            (bpAddr),
        .i_bpValid           (bpValid),
        .i_skipWrite         (skipWrite),
        .i_skipCount         (skipCount),
        .i_resume            (resume),
        .o_breakpointHitN    (hitN),
        .o_hitIndex          (hitIndex),
        .o_hitCount          (hitCount),
        .o_skipRemaining     (skipRem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t V(logic rn, logic en, logic fv, logic [15:0] p,
                               logic w, logic [1:0] wi, logic [15:0] wa, logic wv,
                               logic sw, logic [7:0] sc, logic rs,
                               logic eHitN, logic [1:0] eIdx, logic [7:0] eCnt, logic [7:0] eSkip);
        vec_t v;
        v.rn = rn; v.en = en; v.fv = fv; v.pc = p;
        v.w = w; v.wi = wi; v.wa = wa; v.wv = wv;
        v.sw = sw; v.sc = sc; v.rs = rs;
        v.eHitN = eHitN; v.eIdx = eIdx; v.eCnt = eCnt; v.eSkip = eSkip;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic idleInputs();
        resetn = 1'b1; enN = 1'b0; fetchValid = 1'b0; pc = 16'h0000;
        bpWrite = 1'b0; bpIndex = 2'd0; bpAddr = 16'h0000; bpValid = 1'b0;
        skipWrite = 1'b0; skipCount = 8'd0; resume = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idleInputs();
        // rn en fv pc  w wi wa vv  sw sc rs | hitN idx cnt skip
        vecs.push_back(V(0,0,0,16'h0000, 0,0,16'h0000,0, 0,8'd0,0, 1,0,8'd0,8'd0));  // 0 reset
        vecs.push_back(V(1,0,0,16'h0000, 1,0,16'h0040,1, 0,8'd0,0, 1,0,8'd0,8'd0));  // 1 slot0=0x40
        vecs.push_back(V(1,0,1,16'h0040, 0,0,16'h0000,0, 0,8'd0,0, 0,0,8'd1,8'd0));  // 2 hit slot0
        vecs.push_back(V(1,0,0,16'h0000, 0,0,16'h0000,0, 0,8'd0,1, 1,0,8'd1,8'd0));  // 3 resume
        vecs.push_back(V(1,0,1,16'h0040, 0,0,16'h0000,0, 0,8'd0,0, 1,0,8'd1,8'd0));  // 4 suppressed
        vecs.push_back(V(1,0,0,16'h0000, 1,1,16'h0100,1, 0,8'd0,0, 1,0,8'd1,8'd0));  // 5 slot1
        vecs.push_back(V(1,0,0,16'h0000, 1,3,16'h0100,1, 0,8'd0,0, 1,0,8'd1,8'd0));  // 6 slot3
        vecs.push_back(V(1,0,1,16'h0100, 0,0,16'h0000,0, 0,8'd0,0, 0,1,8'd2,8'd0));  // 7 priority -> 1
        vecs.push_back(V(1,0,0,16'h0000, 0,0,16'h0000,0, 0,8'd0,1, 1,1,8'd2,8'd0));  // 8 resume
        vecs.push_back(V(1,0,1,16'h0100, 0,0,16'h0000,0, 0,8'd0,0, 1,1,8'd2,8'd0));  // 9 suppressed
        vecs.push_back(V(1,0,1,16'h0102, 0,0,16'h0000,0, 0,8'd0,0, 1,1,8'd2,8'd0));  // 10 no match
        vecs.push_back(V(1,0,1,16'h0100, 0,0,16'h0000,0, 0,8'd0,0, 0,1,8'd3,8'd0));  // 11 hit again
        vecs.push_back(V(1,0,0,16'h0000, 0,0,16'h0000,0, 0,8'd0,1, 1,1,8'd3,8'd0));  // 12 resume
        vecs.push_back(V(1,0,1,16'h0102, 0,0,16'h0000,0, 0,8'd0,0, 1,1,8'd3,8'd0));  // 13 suppressed
        vecs.push_back(V(1,0,0,16'h0000, 1,2,16'h0200,1, 1,8'd2,0, 1,1,8'd3,8'd2));  // 14 skip=2 slot2
        vecs.push_back(V(1,0,1,16'h0200, 0,0,16'h0000,0, 0,8'd0,0, 1,1,8'd3,8'd1));  // 15 skipped
        vecs.push_back(V(1,0,1,16'h0200, 0,0,16'h0000,0, 0,8'd0,0, 1,1,8'd3,8'd0));  // 16 skipped
        vecs.push_back(V(1,0,1,16'h0200, 0,0,16'h0000,0, 0,8'd0,0, 0,2,8'd4,8'd0));  // 17 hit slot2
        vecs.push_back(V(1,1,0,16'h0000, 0,0,16'h0000,0, 0,8'd0,0, 1,2,8'd4,8'd0));  // 18 disable in HIT
        vecs.push_back(V(1,0,1,16'h0300, 0,0,16'h0000,0, 0,8'd0,0, 1,2,8'd4,8'd0));  // 19 no match
        vecs.push_back(V(1,1,1,16'h0200, 0,0,16'h0000,0, 0,8'd0,0, 1,2,8'd4,8'd0));  // 20 disabled match
        vecs.push_back(V(1,0,1,16'h0200, 0,0,16'h0000,0, 0,8'd0,0, 0,2,8'd5,8'd0));  // 21 ARMED after disable
        vecs.push_back(V(1,0,0,16'h0000, 0,0,16'h0000,0, 0,8'd0,1, 1,2,8'd5,8'd0));  // 22 resume
        vecs.push_back(V(1,0,1,16'h0300, 0,0,16'h0000,0, 0,8'd0,0, 1,2,8'd5,8'd0));  // 23 suppressed
        vecs.push_back(V(1,0,1,16'h0040, 1,0,16'h0040,0, 0,8'd0,0, 0,0,8'd6,8'd0));  // 24 old contents hit
        vecs.push_back(V(1,0,0,16'h0000, 0,0,16'h0000,0, 0,8'd0,1, 1,0,8'd6,8'd0));  // 25 resume
        vecs.push_back(V(1,0,1,16'h0040, 0,0,16'h0000,0, 0,8'd0,0, 1,0,8'd6,8'd0));  // 26 suppressed
        vecs.push_back(V(1,0,1,16'h0040, 0,0,16'h0000,0, 0,8'd0,0, 1,0,8'd6,8'd0));  // 27 slot0 invalid
        vecs.push_back(V(1,0,0,16'h0000, 0,0,16'h0000,0, 1,8'd3,0, 1,0,8'd6,8'd3));  // 28 load 3
        vecs.push_back(V(1,0,1,16'h0100, 0,0,16'h0000,0, 1,8'd7,0, 1,0,8'd6,8'd7));  // 29 load beats dec
        vecs.push_back(V(1,0,0,16'h0000, 0,0,16'h0000,0, 1,8'd0,0, 1,0,8'd6,8'd0));  // 30 load 0
        vecs.push_back(V(1,0,0,16'h0000, 0,0,16'h0000,0, 0,8'd0,1, 1,0,8'd6,8'd0));  // 31 resume in ARMED
        vecs.push_back(V(1,0,1,16'h0100, 0,0,16'h0000,0, 0,8'd0,0, 0,1,8'd7,8'd0));  // 32 hit, not suppressed
        vecs.push_back(V(1,0,1,16'h0100, 0,0,16'h0000,0, 0,8'd0,1, 1,1,8'd7,8'd0));  // 33 resume+fetch
        vecs.push_back(V(1,0,1,16'h0100, 0,0,16'h0000,0, 0,8'd0,0, 1,1,8'd7,8'd0));  // 34 suppressed
        vecs.push_back(V(1,0,1,16'h0100, 0,0,16'h0000,0, 1,8'd9,0, 0,1,8'd8,8'd9));  // 35 hit, load in HIT
        vecs.push_back(V(0,0,1,16'h0100, 0,0,16'h0000,0, 0,8'd0,0, 1,0,8'd0,8'd0));  // 36 reset mid-HIT
        vecs.push_back(V(1,0,1,16'h0100, 0,0,16'h0000,0, 0,8'd0,0, 1,0,8'd0,8'd0));  // 37 slots cleared
        vecs.push_back(V(1,0,1,16'h0000, 0,0,16'h0000,0, 0,8'd0,0, 1,0,8'd0,8'd0));  // 38 addr0 invalid

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            resetn = vecs[i].rn; enN = vecs[i].en; fetchValid = vecs[i].fv; pc = vecs[i].pc;
            bpWrite = vecs[i].w; bpIndex = vecs[i].wi; bpAddr = vecs[i].wa; bpValid = vecs[i].wv;
            skipWrite = vecs[i].sw; skipCount = vecs[i].sc; resume = vecs[i].rs;
            cycle();
            check("hitN",     i, 32'(hitN),     32'(vecs[i].eHitN));
            check("hitIndex", i, 32'(hitIndex), 32'(vecs[i].eIdx));
            check("hitCount", i, 32'(hitCount), 32'(vecs[i].eCnt));
            check("skipRem",  i, 32'(skipRem),  32'(vecs[i].eSkip));
        end

        // Hand sequence: no combinational path, and hit counter saturation.
        idleInputs();
        bpWrite = 1'b1; bpIndex = 2'd3; bpAddr = 16'h8010; bpValid = 1'b1;
        cycle();
        idleInputs();
        for (int n = 0; n < 260; n++) begin
            fetchValid = 1'b1; pc = 16'h8010;
            #2;
            check("hitN before edge", 1000 + n, 32'(hitN), 32'd1);
            cycle();
            check("sat hitN",  1000 + n, 32'(hitN), 32'd0);
            check("sat index", 1000 + n, 32'(hitIndex), 32'd3);
            check("sat count", 1000 + n, 32'(hitCount), (n + 1 > 255) ? 32'd255 : 32'(n + 1));
            fetchValid = 1'b0; resume = 1'b1;
            cycle();
            resume = 1'b0; fetchValid = 1'b1; pc = 16'h8010;
            cycle();
            fetchValid = 1'b0;
        end

        // Hand sequence: address differing only in the top bit must not match.
        fetchValid = 1'b1; pc = 16'h0010;
        cycle();
        fetchValid = 1'b0;
        check("top bit compare", 2000, 32'(hitN), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
